// File: rtl/inst_buffer.sv
// Instruction buffer between fetch and decode: a circular FIFO of {pc, inst, exc}
// entries with a valid/allowin pop handshake and a one-cycle redirect flush.
module inst_buffer #(
  parameter int DEPTH = 8,
  parameter int AW    = 3
) (
  input  logic          clk,
  input  logic          reset,
  input  logic          flush,
  input  logic          ib_write_req,
  input  logic [31:0]   ib_pc,
  input  logic [31:0]   ib_inst,
  input  logic [2:0]    ib_exc,
  output logic          ib_full,
  input  logic          ds_allowin,
  output logic          ib_to_ds_valid,
  output logic [31:0]   ib_to_ds_pc,
  output logic [31:0]   ib_to_ds_inst,
  output logic [2:0]    ib_to_ds_exc,
  output logic [AW:0]   ib_count
);

  localparam logic [AW:0] FULL_CNT = (AW+1)'(DEPTH);

  logic [31:0]   pc_mem_q   [DEPTH];
  logic [31:0]   pc_mem_d   [DEPTH];
  logic [31:0]   inst_mem_q [DEPTH];
  logic [31:0]   inst_mem_d [DEPTH];
  logic [2:0]    exc_mem_q  [DEPTH];
  logic [2:0]    exc_mem_d  [DEPTH];
  logic [AW-1:0] rd_ptr_q, rd_ptr_d;
  logic [AW-1:0] wr_ptr_q, wr_ptr_d;
  logic [AW:0]   count_q, count_d;
  logic          push;
  logic          pop;

  // Status flags depend only on registered occupancy: fetch builds its
  // write request from ib_full, so any input path here would loop.
  assign ib_full        = (count_q == FULL_CNT);
  assign ib_to_ds_valid = (count_q != '0);
  assign ib_count       = count_q;

  assign ib_to_ds_pc   = pc_mem_q[rd_ptr_q];
  assign ib_to_ds_inst = inst_mem_q[rd_ptr_q];
  assign ib_to_ds_exc  = exc_mem_q[rd_ptr_q];

  assign push = ib_write_req & ~ib_full & ~flush;
  assign pop  = ib_to_ds_valid & ds_allowin & ~flush;

  always_comb begin
    pc_mem_d   = pc_mem_q;
    inst_mem_d = inst_mem_q;
    exc_mem_d  = exc_mem_q;
    rd_ptr_d   = rd_ptr_q;
    wr_ptr_d   = wr_ptr_q;
    count_d    = count_q;
    if (flush) begin
      // Redirect drops everything; stale array contents are never exposed
      // because valid follows count.
      rd_ptr_d = '0;
      wr_ptr_d = '0;
      count_d  = '0;
    end else begin
      if (push) begin
        pc_mem_d[wr_ptr_q]   = ib_pc;
        inst_mem_d[wr_ptr_q] = ib_inst;
        exc_mem_d[wr_ptr_q]  = ib_exc;
        wr_ptr_d             = wr_ptr_q + AW'(1);
      end
      if (pop) begin
        rd_ptr_d = rd_ptr_q + AW'(1);
      end
      if (push && !pop) begin
        count_d = count_q + (AW+1)'(1);
      end else if (pop && !push) begin
        count_d = count_q - (AW+1)'(1);
      end
    end
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      pc_mem_q   <= '{default: '0};
      inst_mem_q <= '{default: '0};
      exc_mem_q  <= '{default: '0};
      rd_ptr_q   <= '0;
      wr_ptr_q   <= '0;
      count_q    <= '0;
    end else begin
      pc_mem_q   <= pc_mem_d;
      inst_mem_q <= inst_mem_d;
      exc_mem_q  <= exc_mem_d;
      rd_ptr_q   <= rd_ptr_d;
      wr_ptr_q   <= wr_ptr_d;
      count_q    <= count_d;
    end
  end

  // Fetch is expected to honour ib_full; a request while full is dropped.
  always_ff @(posedge clk) begin
    if (!reset && !flush) begin
      assert (!(ib_write_req && ib_full))
        else $warning("inst_buffer: write request while full was dropped");
    end
  end

endmodule

// File: tb/tb_inst_buffer.sv
// Scoreboard bench for inst_buffer: accepted pushes are queued as expected
// entries and compared against the head whenever decode pops.
module tb_inst_buffer;

  logic        clk = 1'b0;
  logic        reset, flush, ib_write_req, ds_allowin;
  logic [31:0] ib_pc, ib_inst;
  logic [2:0]  ib_exc;
  logic        ib_full, ib_to_ds_valid;
  logic [31:0] ib_to_ds_pc, ib_to_ds_inst;
  logic [2:0]  ib_to_ds_exc;
  logic [3:0]  ib_count;

  logic [66:0] exp_q[$];
  logic [66:0] head;
  int errors = 0;
  int checks = 0;

  always #5 clk = ~clk;

  inst_buffer #(.DEPTH(8), .AW(3)) dut (
    .clk(clk), .reset(reset), .flush(flush), .ib_write_req(ib_write_req),
    .ib_pc(ib_pc), .ib_inst(ib_inst), .ib_exc(ib_exc), .ib_full(ib_full),
    .ds_allowin(ds_allowin), .ib_to_ds_valid(ib_to_ds_valid),
    .ib_to_ds_pc(ib_to_ds_pc), .ib_to_ds_inst(ib_to_ds_inst),
    .ib_to_ds_exc(ib_to_ds_exc), .ib_count(ib_count)
  );

  // Drive one cycle of stimulus, update the reference queue, advance to edge+1.
  task automatic tick(input logic wr, input logic [31:0] pc, input logic [2:0] exc,
                      input logic alw, input logic fl);
    logic [31:0] inst;
    int n;
    inst = pc ^ 32'h0280_0C0C;
    ib_write_req = wr; ib_pc = pc; ib_inst = inst; ib_exc = exc;
    ds_allowin = alw; flush = fl;
    n = exp_q.size();
    if (fl) exp_q.delete();
    else begin
      if (alw && n != 0) void'(exp_q.pop_front());
      if (wr && n < 8) exp_q.push_back({pc, inst, exc});
    end
    @(posedge clk); #1;
    ib_write_req = 1'b0; ds_allowin = 1'b0; flush = 1'b0;
  endtask

  task automatic test_reset();
    reset = 1'b1; flush = 1'b0; ib_write_req = 1'b0; ds_allowin = 1'b0;
    ib_pc = '0; ib_inst = '0; ib_exc = '0;
    repeat (2) @(posedge clk);
    #1 reset = 1'b0;
    exp_q.delete();
    checks++;
    if ({ib_full, ib_to_ds_valid, ib_count} !== 6'd0) begin
      errors++; $display("FAIL reset_flags: got full=%b valid=%b count=%0d want 0 0 0",
                         ib_full, ib_to_ds_valid, ib_count);
    end
    checks++;
    if ({ib_to_ds_pc, ib_to_ds_inst, ib_to_ds_exc} !== 67'd0) begin
      errors++; $display("FAIL reset_data: got pc=%h inst=%h exc=%b want all 0",
                         ib_to_ds_pc, ib_to_ds_inst, ib_to_ds_exc);
    end
  endtask

  task automatic test_single_push();
    tick(1'b1, 32'h1C00_0000, 3'b000, 1'b0, 1'b0);
    head = exp_q[0];
    checks++;
    if (ib_to_ds_valid !== 1'b1 || ib_count !== 4'd1 || ib_to_ds_pc !== 32'h1C00_0000
        || ib_to_ds_inst !== 32'h1E80_0C0C) begin
      errors++; $display("FAIL single_push: got valid=%b count=%0d pc=%h inst=%h want 1 1 1c000000 1e800c0c",
                         ib_to_ds_valid, ib_count, ib_to_ds_pc, ib_to_ds_inst);
    end
    tick(1'b0, 32'h0, 3'b000, 1'b1, 1'b0);
    checks++;
    if (ib_to_ds_valid !== 1'b0 || ib_count !== 4'd0) begin
      errors++; $display("FAIL single_pop: got valid=%b count=%0d want 0 0", ib_to_ds_valid, ib_count);
    end
  endtask

  task automatic test_fill_drain();
    for (int k = 0; k < 8; k++) begin
      checks++;
      if (ib_full !== 1'b0) begin
        errors++; $display("FAIL fill_notfull_%0d: got full=%b want 0", k, ib_full);
      end
      tick(1'b1, 32'h1C00_0000 + 32'(4*k), 3'b000, 1'b0, 1'b0);
    end
    checks++;
    if (ib_full !== 1'b1 || ib_count !== 4'd8) begin
      errors++; $display("FAIL fill_full: got full=%b count=%0d want 1 8", ib_full, ib_count);
    end
    tick(1'b1, 32'h1C00_0020, 3'b000, 1'b0, 1'b0);
    checks++;
    if (ib_count !== 4'd8 || ib_to_ds_pc !== 32'h1C00_0000) begin
      errors++; $display("FAIL push_when_full: got count=%0d head=%h want 8 1c000000", ib_count, ib_to_ds_pc);
    end
    for (int k = 0; k < 8; k++) begin
      head = exp_q[0];
      checks++;
      if (ib_to_ds_valid !== 1'b1 || {ib_to_ds_pc, ib_to_ds_inst, ib_to_ds_exc} !== head) begin
        errors++; $display("FAIL drain_order_%0d: got valid=%b pc=%h want 1 %h", k, ib_to_ds_valid,
                           ib_to_ds_pc, head[66:35]);
      end
      tick(1'b0, 32'h0, 3'b000, 1'b1, 1'b0);
    end
    checks++;
    if (ib_count !== 4'd0 || ib_to_ds_valid !== 1'b0) begin
      errors++; $display("FAIL drain_empty: got count=%0d valid=%b want 0 0", ib_count, ib_to_ds_valid);
    end
  endtask

  task automatic test_wrap();
    for (int k = 0; k < 8; k++) tick(1'b1, 32'h1C00_0100 + 32'(4*k), 3'b000, 1'b0, 1'b0);
    tick(1'b0, 32'h0, 3'b000, 1'b1, 1'b0);
    checks++;
    if (ib_count !== 4'd7 || ib_full !== 1'b0) begin
      errors++; $display("FAIL full_pop: got count=%0d full=%b want 7 0", ib_count, ib_full);
    end
    tick(1'b1, 32'h1C00_0120, 3'b000, 1'b0, 1'b0);
    checks++;
    if (ib_count !== 4'd8 || ib_full !== 1'b1) begin
      errors++; $display("FAIL refill: got count=%0d full=%b want 8 1", ib_count, ib_full);
    end
    for (int k = 0; k < 8; k++) begin
      head = exp_q[0];
      checks++;
      if ({ib_to_ds_pc, ib_to_ds_inst, ib_to_ds_exc} !== head) begin
        errors++; $display("FAIL wrap_order_%0d: got pc=%h want %h", k, ib_to_ds_pc, head[66:35]);
      end
      tick(1'b0, 32'h0, 3'b000, 1'b1, 1'b0);
    end
  endtask

  task automatic test_back_to_back();
    for (int k = 0; k < 3; k++) tick(1'b1, 32'h1C00_0200 + 32'(4*k), 3'b000, 1'b0, 1'b0);
    for (int k = 3; k < 23; k++) begin
      head = exp_q[0];
      checks++;
      if (ib_count !== 4'd3 || {ib_to_ds_pc, ib_to_ds_inst, ib_to_ds_exc} !== head) begin
        errors++; $display("FAIL stream_%0d: got count=%0d pc=%h want 3 %h", k, ib_count,
                           ib_to_ds_pc, head[66:35]);
      end
      tick(1'b1, 32'h1C00_0200 + 32'(4*k), 3'b000, 1'b1, 1'b0);
    end
    for (int k = 0; k < 3; k++) begin
      head = exp_q[0];
      checks++;
      if ({ib_to_ds_pc, ib_to_ds_inst, ib_to_ds_exc} !== head) begin
        errors++; $display("FAIL stream_tail_%0d: got pc=%h want %h", k, ib_to_ds_pc, head[66:35]);
      end
      tick(1'b0, 32'h0, 3'b000, 1'b1, 1'b0);
    end
  endtask

  task automatic test_flush();
    for (int k = 0; k < 5; k++) tick(1'b1, 32'h1C00_0300 + 32'(4*k), 3'b000, 1'b0, 1'b0);
    tick(1'b1, 32'h1C00_0400, 3'b001, 1'b1, 1'b1);
    checks++;
    if (ib_count !== 4'd0 || ib_to_ds_valid !== 1'b0 || ib_full !== 1'b0) begin
      errors++; $display("FAIL flush: got count=%0d valid=%b full=%b want 0 0 0",
                         ib_count, ib_to_ds_valid, ib_full);
    end
    tick(1'b1, 32'h1C00_0500, 3'b010, 1'b0, 1'b0);
    head = exp_q[0];
    checks++;
    if (ib_to_ds_valid !== 1'b1 || {ib_to_ds_pc, ib_to_ds_inst, ib_to_ds_exc} !== head) begin
      errors++; $display("FAIL post_flush_head: got valid=%b pc=%h exc=%b want 1 %h %b",
                         ib_to_ds_valid, ib_to_ds_pc, ib_to_ds_exc, head[66:35], head[2:0]);
    end
    tick(1'b0, 32'h0, 3'b000, 1'b1, 1'b0);
  endtask

  task automatic test_exc_and_reset();
    for (int k = 0; k < 8; k++)
      tick(1'b1, 32'h1C00_0000 + 32'(4*k), (k == 4) ? 3'b100 : 3'b000, 1'b0, 1'b0);
    for (int k = 0; k < 8; k++) begin
      head = exp_q[0];
      checks++;
      if ({ib_to_ds_pc, ib_to_ds_inst, ib_to_ds_exc} !== head) begin
        errors++; $display("FAIL exc_travel_%0d: got pc=%h exc=%b want %h %b", k, ib_to_ds_pc,
                           ib_to_ds_exc, head[66:35], head[2:0]);
      end
      tick(1'b0, 32'h0, 3'b000, 1'b1, 1'b0);
    end
    for (int k = 0; k < 4; k++) tick(1'b1, 32'h1C00_0600 + 32'(4*k), 3'b000, 1'b0, 1'b0);
    checks++;
    if (ib_count !== 4'd4) begin
      errors++; $display("FAIL pre_reset_count: got %0d want 4", ib_count);
    end
    reset = 1'b1; ib_write_req = 1'b1; ds_allowin = 1'b1; ib_pc = 32'h1C00_0700;
    @(posedge clk); #1;
    reset = 1'b0; ib_write_req = 1'b0; ds_allowin = 1'b0;
    exp_q.delete();
    checks++;
    if (ib_count !== 4'd0 || ib_to_ds_valid !== 1'b0 || ib_full !== 1'b0) begin
      errors++; $display("FAIL mid_reset: got count=%0d valid=%b full=%b want 0 0 0",
                         ib_count, ib_to_ds_valid, ib_full);
    end
  endtask

  initial begin
    test_reset();
    test_single_push();
    test_fill_drain();
    test_wrap();
    test_back_to_back();
    test_flush();
    test_exc_and_reset();
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
